debounce_filter: RTL and testbench

Input-conditioning stage placed directly upstream of the edge and pulse detectors. It takes an asynchronous, possibly bouncing external level, synchronizes it into `clk`, and rejects any level change that does not persist for `STABLE_CYCLES` consecutive synchronized samples. It outputs a clean level plus registered one-cycle rise and fall strobes, so downstream detectors only ever see glitch-free, synchronous signals.

---
 rtl/debounce_filter.sv | 120 ++++++++++++
 tb/tb_debounce_filter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_filter.sv
// debounce_filter: synchronizes an asynchronous level and accepts a change only
//   after STABLE_CYCLES consecutive mismatching synchronized samples.
// Latency: a_clean/rise/fall update SYNC_STAGES+STABLE_CYCLES edges after
//   the first edge that samples a new, held a_raw level.
// Backpressure: none; free-running input conditioner.
// Optional feature: define DEBOUNCE_GLITCH_CNT_EN to add the saturating
//   8-bit glitch_cnt output counting abandoned change attempts.
module debounce_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_raw,
  output logic       a_clean,
  output logic       rise,
  output logic       fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  // A single-cycle filter still needs a 1-bit counter to keep the datapath legal.
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   a_s;

  logic             clean_q, clean_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Synchronizer chain: plain shift register, nothing between stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a_raw};
    end
  end

  assign a_s = sync_q[SYNC_STAGES-1];

  // Next-state: any matching sample discards the accumulated count; the
  // STABLE_CYCLES-th consecutive mismatch flips the clean level and strobes.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (a_s == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      clean_d = a_s;
      cnt_d   = '0;
      rise_d  = a_s;
      fall_d  = ~a_s;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Filter state and registered strobes; reset aborts any pending change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a_clean = clean_q;
  assign rise    = rise_q;
  assign fall    = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic       glitch_ev;
  logic [7:0] glitch_q, glitch_d;

  // A glitch is a matching sample arriving while a change was being counted.
  assign glitch_ev = (a_s == clean_q) && (cnt_q != '0);

  // Saturating increment: holds at 255 rather than wrapping.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_ev && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  // Glitch counter register, cleared with the rest of the filter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glitch_q <= 8'h00;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

  // Strobes are mutually exclusive and always agree with the new clean level.
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst)
    !(rise_q && fall_q));
  a_rise_level: assert property (@(posedge clk) disable iff (!rst)
    rise_q |-> clean_q);
  a_fall_level: assert property (@(posedge clk) disable iff (!rst)
    fall_q |-> !clean_q);

endmodule

// File: tb/tb_debounce_filter.sv
module tb_debounce_filter;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_raw = 1'b0;
  logic a_clean, rise, fall;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  debounce_filter #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_raw      (a_raw),
    .a_clean    (a_clean),
    .rise       (rise),
    .fall       (fall)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  // Reference model: a_raw delayed through a queue, plus the list of
  // synchronized samples seen since the last matching sample or accepted change.
  bit m_sync[$];
  bit m_hist[$];
  bit m_clean, m_rise, m_fall;
  int m_glitch;

  function void model_reset();
    m_sync = {};
    for (int i = 0; i < SYNC; i++) m_sync.push_back(1'b0);
    m_hist   = {};
    m_clean  = 1'b0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_glitch = 0;
  endfunction

  function void model_step(bit a);
    bit s;
    int tail;
    m_sync.push_back(a);
    s = m_sync.pop_front();
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s == m_clean) begin
      if (m_hist.size() > 0 && m_glitch < 255) m_glitch++;
      m_hist = {};
    end else begin
      m_hist.push_back(s);
      tail = m_hist.size();
      if (tail >= STABLE) begin
        m_clean = s;
        m_rise  = s;
        m_fall  = !s;
        m_hist  = {};
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive a_raw, let the edge sample it, then compare against the model.
  task automatic tick(input bit a);
    a_raw = a;
    @(posedge clk);
    model_step(a);
    #1;
    check("clean", a_clean, m_clean);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("strobe_excl", rise & fall, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch", glitch_cnt, m_glitch);
`endif
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    a_raw = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) tick(1'b0);
  endtask

  // Applies a level for n ticks, reporting the first tick (1-based from the
  // start of this call, offset by base) with a rise/fall, and strobe counts.
  task automatic hold(input bit a, input int n, input int base,
                      inout int rise_at, inout int fall_at,
                      inout int n_rise, inout int n_fall);
    for (int k = 1; k <= n; k++) begin
      tick(a);
      if (rise) begin n_rise++; if (rise_at == 0) rise_at = base + k; end
      if (fall) begin n_fall++; if (fall_at == 0) fall_at = base + k; end
    end
  endtask

  typedef struct {
    bit a;
    bit clean;
    bit rise;
    bit fall;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int ra, fa, nr, nf, g0;
    bit v;
    int len;

    vecs[0]  = '{1, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0};
    vecs[5]  = '{1, 1, 1, 0};
    vecs[6]  = '{1, 1, 0, 0};
    vecs[7]  = '{1, 1, 0, 0};
    vecs[8]  = '{0, 1, 0, 0};
    vecs[9]  = '{0, 1, 0, 0};
    vecs[10] = '{0, 1, 0, 0};
    vecs[11] = '{0, 1, 0, 0};
    vecs[12] = '{0, 1, 0, 0};
    vecs[13] = '{0, 0, 0, 1};
    vecs[14] = '{0, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 0};

    // Reset/idle: a_raw high during reset, low after release; nothing moves.
    a_raw = 1'b1;
    model_reset();
    #1;
    check("rst_clean", a_clean, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_hold_clean", a_clean, 0);
      check("rst_hold_strobe", rise | fall, 0);
    end
    rst = 1'b1;
    ra = 0; fa = 0; nr = 0; nf = 0;
    hold(1'b0, 10, 0, ra, fa, nr, nf);
    check("idle_rises", nr, 0);
    check("idle_falls", nf, 0);

    // Clean rise then fall, table driven.
    for (int i = 0; i < 16; i++) begin
      tick(vecs[i].a);
      check($sformatf("vec%0d_clean", i), a_clean, vecs[i].clean);
      check($sformatf("vec%0d_rise", i), rise, vecs[i].rise);
      check($sformatf("vec%0d_fall", i), fall, vecs[i].fall);
    end

    // Glitch of 3 samples is rejected and counted; repeated, the count saturates.
    do_reset();
    ra = 0; fa = 0; nr = 0; nf = 0;
    hold(1'b1, 3, 0, ra, fa, nr, nf);
    hold(1'b0, 5, 3, ra, fa, nr, nf);
    check("glitch3_rises", nr, 0);
    check("glitch3_clean", a_clean, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch3_cnt", glitch_cnt, 1);
`endif
    repeat (299) begin
      hold(1'b1, 3, 0, ra, fa, nr, nf);
      hold(1'b0, 5, 3, ra, fa, nr, nf);
    end
    check("glitch300_rises", nr, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch300_sat", glitch_cnt, 255);
`endif

    // Boundary width: exactly STABLE samples high is accepted.
    do_reset();
    ra = 0; fa = 0; nr = 0; nf = 0;
    hold(1'b1, 4, 0, ra, fa, nr, nf);
    hold(1'b0, 12, 4, ra, fa, nr, nf);
    check("bound_rise_at", ra, 6);
    check("bound_fall_at", fa, 10);
    check("bound_n_rise", nr, 1);
    check("bound_n_fall", nf, 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("bound_glitch", glitch_cnt, 0);
`endif

    // Bounce train: only the final long run is accepted.
    do_reset();
    ra = 0; fa = 0; nr = 0; nf = 0;
    hold(1'b1, 1, 0, ra, fa, nr, nf);
    hold(1'b0, 1, 1, ra, fa, nr, nf);
    hold(1'b1, 2, 2, ra, fa, nr, nf);
    hold(1'b0, 1, 4, ra, fa, nr, nf);
    hold(1'b1, 12, 5, ra, fa, nr, nf);
    check("bounce_n_rise", nr, 1);
    check("bounce_rise_at", ra, 11);
    check("bounce_clean", a_clean, 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("bounce_glitch", glitch_cnt, 2);
`endif

    // Asynchronous reset while a_clean is high clears it without a clock edge.
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("async_clean", a_clean, 0);
    check("async_strobe", rise | fall, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset mid-count aborts the change; a_raw still high after release rises again.
    do_reset();
    ra = 0; fa = 0; nr = 0; nf = 0;
    hold(1'b1, 4, 0, ra, fa, nr, nf);
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_clean", a_clean, 0);
    check("midrst_rise", rise, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("midrst_hold", a_clean | rise | fall, 0);
    end
    rst = 1'b1;
    hold(1'b1, 10, 0, ra, fa, nr, nf);
    check("midrst_n_rise", nr, 1);
    check("midrst_rise_at", ra, 6);

    // Randomized runs of random length, checked cycle by cycle against the model.
    do_reset();
    ra = 0; fa = 0; nr = 0; nf = 0;
    g0 = 0;
    for (int r = 0; r < 300; r++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      hold(v, len, 0, ra, fa, nr, nf);
      g0 += len;
    end
    check("rand_ran", (g0 >= 300), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
